// File: rtl/pkt_sink_checker_if.sv
// Valid/ready packet channel between a router output and its sink.
// The producer holds in_data stable until in_valid & in_ready.
interface pkt_sink_checker_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pkt_sink_checker.sv
// Clocked packet sink: throttled handshake, destination check,
// per-source/total counts and done after a programmed count.
module pkt_sink_checker #(
  parameter int         WIDTH     = 11,
  parameter int         SRC_BITS  = 3,
  parameter int         DST_BITS  = 3,
  parameter int         PORT_ID   = 0,
  parameter int         CNT_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                             clk,
  input  logic                             reset_n,
  pkt_sink_checker_if.slave                in_if,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 expect_cnt,
  input  logic                             stall_en,
  output logic [CNT_W-1:0]                 total_cnt,
  output logic [(2**SRC_BITS)*CNT_W-1:0]   src_cnt,
  output logic [WIDTH-1:0]                 last_data,
  output logic                             err_dst,
  output logic [WIDTH-1:0]                 err_data,
  output logic                             err_extra,
  output logic                             done
);

  localparam int NSRC = 2**SRC_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             expect_q, expect_d;
  logic [7:0]                   lfsr_q, lfsr_d;
  logic                         ready_q, ready_d;
  logic [CNT_W-1:0]             total_q, total_d;
  logic [NSRC-1:0][CNT_W-1:0]   src_q, src_d;
  logic [WIDTH-1:0]             last_q, last_d;
  logic                         err_dst_q, err_dst_d;
  logic [WIDTH-1:0]             err_data_q, err_data_d;
  logic                         err_extra_q, err_extra_d;

  logic                         xfer;
  logic                         fb;
  logic [DST_BITS-1:0]          dst;
  logic [SRC_BITS-1:0]          src;

  assign dst  = in_if.in_data[DST_BITS-1:0];
  assign src  = in_if.in_data[DST_BITS+SRC_BITS-1:DST_BITS];
  assign xfer = in_if.in_valid & ready_q;
  assign fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    lfsr_d      = lfsr_q;
    ready_d     = ready_q;
    total_d     = total_q;
    src_d       = src_q;
    last_d      = last_q;
    err_dst_d   = err_dst_q;
    err_data_d  = err_data_q;
    err_extra_d = err_extra_q;

    if (xfer) begin
      total_d = (&total_q) ? total_q : total_q + 1'b1;
      src_d[src] = (&src_q[src]) ? src_q[src] : src_q[src] + 1'b1;
      last_d = in_if.in_data;
      if (dst != DST_BITS'(PORT_ID) && !err_dst_q) begin
        err_dst_d  = 1'b1;
        err_data_d = in_if.in_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
      end
      S_RUN: begin
        lfsr_d  = {lfsr_q[6:0], fb};
        ready_d = stall_en ? ~lfsr_q[0] : 1'b1;
        if ((xfer && total_d == expect_q) || expect_q == '0) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        if (xfer) err_extra_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase

    // Clear wins over any transfer in the same cycle; LFSR keeps running.
    if (start) begin
      state_d     = S_RUN;
      expect_d    = expect_cnt;
      ready_d     = 1'b0;
      total_d     = '0;
      src_d       = '0;
      last_d      = last_q;
      err_dst_d   = 1'b0;
      err_data_d  = '0;
      err_extra_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      expect_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      ready_q     <= 1'b0;
      total_q     <= '0;
      src_q       <= '0;
      last_q      <= '0;
      err_dst_q   <= 1'b0;
      err_data_q  <= '0;
      err_extra_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      lfsr_q      <= lfsr_d;
      ready_q     <= ready_d;
      total_q     <= total_d;
      src_q       <= src_d;
      last_q      <= last_d;
      err_dst_q   <= err_dst_d;
      err_data_q  <= err_data_d;
      err_extra_q <= err_extra_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign total_cnt      = total_q;
  assign src_cnt        = src_q;
  assign last_data      = last_q;
  assign err_dst        = err_dst_q;
  assign err_data       = err_data_q;
  assign err_extra      = err_extra_q;
  assign done           = (state_q == S_DONE);

endmodule

// File: doc/pkt_sink_checker.md
Name: pkt_sink_checker

Overview:
- Clocked, parametrised successor to the 11-bit packet bit-bucket sink.
- Terminates one router output channel through a valid/ready handshake and can apply pseudo-random backpressure.
- Checks each packet's destination field against its own port ID and keeps per-source and total packet counts.
- Raises done after a programmed packet count; errors are sticky.
- One instance per router output in the clocked all-to-one / all-to-all test harnesses.

Parameters:
- WIDTH, 11, packet width; bit layout is {route, src, dst}.
- SRC_BITS, 3, width of the source field.
- DST_BITS, 3, width of the destination field (data[DST_BITS-1:0]).
- PORT_ID, 0, destination ID this sink owns.
- CNT_W, 8, width of every counter.
- LFSR_SEED, 8'hA5, backpressure LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear counters and errors, then enter RUN.
- expect_cnt  in  CNT_W  number of packets expected; sampled on start.
- stall_en  in  1  enable LFSR backpressure while in RUN.
- in_valid  in  1  producer has a packet.
- in_data  in  WIDTH  packet.
- in_ready  out  1  sink accepts this cycle; registered.
- total_cnt  out  CNT_W  packets accepted since start.
- src_cnt  out  (2**SRC_BITS)*CNT_W  per-source counts; source s occupies bits [s*CNT_W +: CNT_W].
- last_data  out  WIDTH  most recently accepted packet.
- err_dst  out  1  sticky: a packet arrived whose dst != PORT_ID.
- err_data  out  WIDTH  first packet that set err_dst.
- err_extra  out  1  sticky: a packet was accepted while in DONE.
- done  out  1  high while in DONE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; in_ready=0; all counters, last_data, err_data and error flags = 0; done=0.
  - expect register = 0; LFSR = LFSR_SEED.
- Transfer: occurs on a rising edge where in_valid & in_ready. The producer must hold in_data stable until the transfer.
- On each transfer:
  - total_cnt and src_cnt[src] increment, saturating at all-ones (no wrap).
  - last_data <= in_data.
  - If dst != PORT_ID and err_dst==0: set err_dst and capture err_data.
- States:
  - IDLE: in_ready=0. start -> RUN; expect <= expect_cnt.
  - RUN:
    - in_ready(next) = stall_en ? ~lfsr[0] : 1.
    - LFSR advances every RUN cycle: Fibonacci, taps 8,6,5,4; shift left, feedback into bit 0.
    - When a transfer makes total_cnt == expect: go to DONE next cycle.
    - If expect==0 at start: RUN lasts one cycle and accepts nothing (in_ready=0 during that cycle), then DONE.
  - DONE:
    - done=1; in_ready=1 unconditionally.
    - Any transfer still updates counters and last_data and sets err_extra.
    - start -> RUN with the full clear.
- start while in RUN or DONE:
  - Clears total_cnt, src_cnt, err_dst, err_data, err_extra and done; reloads expect; enters RUN.
  - A transfer in the same cycle is discarded (clear has priority).
  - The LFSR is not reseeded.
- in_ready latency: registered, so a stall decision takes effect on the cycle after the LFSR step. A valid held across stall cycles is accepted exactly once.
- Reset asserted mid-RUN: immediate return to the reset values above; the next packet is not accepted until a new start.
- Counters are CNT_W wide.
- SRC/DST extraction:
  - dst = in_data[DST_BITS-1:0]
  - src = in_data[DST_BITS+SRC_BITS-1:DST_BITS]
  - route bits above these are ignored.

Test Plan:
1. Reset values: hold reset_n=0 with in_valid=1 -> in_ready=0, all counts 0, done=0, err_* = 0. Release reset with no start -> in_ready stays 0 indefinitely.
2. All-to-C, PORT_ID=2, expect_cnt=7, stall_en=0. Send 01000_000_010, 01000_001_010, 10000_011_010, 00110_100_010, 00110_101_010, 00110_110_010, 00110_111_010 back-to-back -> total_cnt=7; src_cnt[2]=0, every other src_cnt=1; done=1 the cycle after the 7th transfer; err_dst=0.
3. Wrong destination: PORT_ID=2, send 01100_000_011 then 01100_001_011 -> err_dst=1, err_data=11'b01100_000_011 (first bad packet); total_cnt=2.
4. Extra packet: after scenario 2, send 00111_100_011 -> err_extra=1, total_cnt=8, last_data updated. A start pulse then clears both errors, total_cnt=0, done=0.
5. Backpressure: stall_en=1, expect_cnt=20, producer holds each packet until accepted -> all 20 packets counted exactly once, in order, with in_ready low on some cycles. A start coinciding with a transfer -> that packet is not counted.
6. Edge cases:
   - expect_cnt=0 -> done one cycle after RUN, nothing accepted in RUN.
   - CNT_W=4 with 20 packets -> total_cnt saturates at 15.
   - reset_n low mid-RUN -> immediate reset values.
